psram_arb: RTL and testbench
============================

// Module: psram_arb
// PURPOSE
//  Two-requester arbiter in front of the PSRAM cr_int transaction port (dt_req/dt_ack/rw, data, max_addr, reg_addr).
//  Port 0 is the AHB-side CPU path; port 1 is the camera/DMA frame-buffer path.
//  Serialises transactions, enforces fairness with a starvation limit and flags a watchdog error if cr_int never acknowledges.
// PARAMETERS
//  STARVE_LIMIT  4    max back-to-back grants to one port while the other is requesting (1..15)
//  ACK_TIMEOUT   255  cycles to wait for dt_ack before aborting (1..255)
// PORTS
//  clk          in   1   system clock (HCLK domain)
//  clr          in   1   synchronous reset, active-high
//  m0_req       in   1   port 0 transaction request; held high until m0_ack
//  m0_rw        in   1   port 0 direction: 1 = write, 0 = read
//  m0_wdata     in   16  port 0 write data
//  m0_max_addr  in   32  port 0 PSRAM address
//  m0_reg_addr  in   32  port 0 CR register address
//  m0_ack       out  1   port 0 completion pulse (1 cycle)
//  m0_err       out  1   port 0 timeout pulse (1 cycle, coincident with m0_ack)
//  m1_*         same set of signals as m0_* for port 1
//  rdata        out  16  read data, valid in the m0_ack/m1_ack cycle
//  dt_req       out  1   request to cr_int
//  dt_rw        out  1   direction to cr_int
//  data_to_cr   out  16  write data to cr_int
//  max_addr     out  32  PSRAM address to cr_int
//  reg_addr     out  32  CR register address to cr_int
//  dt_ack       in   1   cr_int completion pulse
//  data_from_cr in   16  cr_int read data, valid with dt_ack
//  busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset (clr=1 at a clk edge) forces:
//    - state IDLE;
//    - all outputs 0, including dt_req, m*_ack, m*_err, busy, rdata, data_to_cr, max_addr, reg_addr;
//    - streak counter 0, last-owner = 1 (so port 0 wins the first tie).
//  - Reset mid-transaction abandons the transaction with no ack or err.
//  - FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  - IDLE: sample m0_req/m1_req.
//    - Only one requesting: grant it.
//    - Both requesting: grant port 0, unless port 0 owned the last grant and the streak counter == STARVE_LIMIT; then grant port 1.
//    - The rule is symmetric for port 1 at its streak limit.
//    - On grant, latch the owner's rw/wdata/max_addr/reg_addr into output registers and go to ISSUE.
//  - ISSUE: assert dt_req (registered, first high the cycle after the grant) -> WAIT.
//  - WAIT: hold dt_req and all latched fields stable.
//    - On dt_ack: capture data_from_cr into rdata, drop dt_req next cycle, go to DONE.
//    - Timeout counter is cleared on entry and increments each WAIT cycle.
//    - At ACK_TIMEOUT with no dt_ack: drop dt_req, set the err flag, go to DONE, rdata = 16'h0000.
//  - DONE: pulse the owner's m*_ack (and m*_err if flagged) for exactly one cycle -> IDLE.
//    - Minimum latency: request seen in IDLE at cycle 0, dt_req high at cycle 1; dt_ack at cycle k gives m_ack at cycle k+1.
//    - Back-to-back: the next grant can be taken in the IDLE cycle following DONE.
//  - Streak counter:
//    - Increments when the new owner equals last-owner; otherwise resets to 1.
//    - Saturates at STARVE_LIMIT.
//    - Updated only when a grant is taken.
//  - Requesters must hold m*_req and their fields until their ack; a request that drops before being granted is ignored.
//  - A dt_ack outside WAIT is ignored. A dt_ack arriving in the same cycle the timeout expires counts as success (no err).
//  - The non-owner's ack and err stay 0 for the whole transaction.
// TESTING
//  1) Port 0 read, max_addr=0x100, dt_ack 3 cycles after dt_req, data_from_cr=0xBEEF -> m0_ack one cycle after dt_ack, rdata=0xBEEF; m1_ack stays 0.
//  2) m0_req and m1_req held continuously, STARVE_LIMIT=4, dt_ack after 1 cycle -> grant order 0,0,0,0,1,0,0,0,0,1...; neither port waits more than 4 transactions.
//  3) Only m1_req, write wdata=0x1234, reg_addr=0x8 -> dt_rw=1, data_to_cr=0x1234, reg_addr=0x8 stable from dt_req rise through dt_ack.
//  4) dt_ack never arrives, ACK_TIMEOUT=8 -> dt_req drops after 8 WAIT cycles; m0_ack and m0_err pulse together; rdata=0; next request is served normally.
//  5) clr asserted during WAIT -> next cycle dt_req=0, busy=0, no ack pulse; a following m1_req is granted with no stale data.
//  6) Stray dt_ack pulse in IDLE, then a port 0 read -> stray pulse ignored; port 0 completes only on its own dt_ack.

Source files
------------

// File: rtl/psram_arb.sv
// psram_arb: two-port fair arbiter in front of the cr_int transaction port.
// Owner's fields are latched at grant and held until cr_int acks or the watchdog expires.
module psram_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [15:0] m0_wdata,
    input  logic [31:0] m0_max_addr,
    input  logic [31:0] m0_reg_addr,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [15:0] m1_wdata,
    input  logic [31:0] m1_max_addr,
    input  logic [31:0] m1_reg_addr,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] rdata,
    output logic        dt_req,
    output logic        dt_rw,
    output logic [15:0] data_to_cr,
    output logic [31:0] max_addr,
    output logic [31:0] reg_addr,
    input  logic        dt_ack,
    input  logic [15:0] data_from_cr,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;
    localparam logic [3:0] SL = 4'(STARVE_LIMIT);
    localparam logic [7:0] TO = 8'(ACK_TIMEOUT - 1);
    state_t      state;
    logic        own, last, any, gnt;
    logic [3:0]  streak;
    logic [7:0]  tcnt;
    // on a tie port 0 wins unless it has just used up its streak
    always_comb begin
        any = m0_req | m1_req;
        gnt = (m0_req & m1_req) ? (!last && streak == SL) : m1_req;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            own        <= 1'b0;
            last       <= 1'b1;
            streak     <= 4'd0;
            tcnt       <= 8'd0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            rdata      <= 16'h0000;
            dt_req     <= 1'b0;
            dt_rw      <= 1'b0;
            data_to_cr <= 16'h0000;
            max_addr   <= 32'h0;
            reg_addr   <= 32'h0;
            busy       <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    own        <= gnt;
                    last       <= gnt;
                    streak     <= (gnt == last) ? ((streak == SL) ? SL : streak + 4'd1) : 4'd1;
                    dt_rw      <= gnt ? m1_rw : m0_rw;
                    data_to_cr <= gnt ? m1_wdata : m0_wdata;
                    max_addr   <= gnt ? m1_max_addr : m0_max_addr;
                    reg_addr   <= gnt ? m1_reg_addr : m0_reg_addr;
                    dt_req     <= 1'b1;
                    busy       <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    tcnt  <= 8'd0;
                    state <= WAIT_ACK;
                end
                // an ack on the final watchdog cycle still counts as success
                WAIT_ACK: if (dt_ack || tcnt == TO) begin
                    dt_req <= 1'b0;
                    rdata  <= dt_ack ? data_from_cr : 16'h0000;
                    m0_ack <= !own;
                    m1_ack <= own;
                    m0_err <= !own && !dt_ack;
                    m1_err <= own && !dt_ack;
                    state  <= DONE;
                end else begin
                    tcnt <= tcnt + 8'd1;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_psram_arb.sv
// tb_psram_arb: table of directed transactions plus hand-written reset, stray-ack and fairness sequences.
module tb_psram_arb;
    localparam int TO = 8;
    logic        clk = 1'b0, clr = 1'b1;
    logic        m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0, dt_ack = 1'b0;
    logic [15:0] m0_wdata = 16'h0, m1_wdata = 16'h0, data_from_cr = 16'h0;
    logic [31:0] m0_max_addr = 32'h0, m0_reg_addr = 32'h0, m1_max_addr = 32'h0, m1_reg_addr = 32'h0;
    logic        m0_ack, m0_err, m1_ack, m1_err, dt_req, dt_rw, busy;
    logic [15:0] rdata, data_to_cr;
    logic [31:0] max_addr, reg_addr;
    int checks = 0, errors = 0;

    psram_arb #(.STARVE_LIMIT(4), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_wdata(m0_wdata), .m0_max_addr(m0_max_addr),
        .m0_reg_addr(m0_reg_addr), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_wdata(m1_wdata), .m1_max_addr(m1_max_addr),
        .m1_reg_addr(m1_reg_addr), .m1_ack(m1_ack), .m1_err(m1_err),
        .rdata(rdata), .dt_req(dt_req), .dt_rw(dt_rw), .data_to_cr(data_to_cr),
        .max_addr(max_addr), .reg_addr(reg_addr), .dt_ack(dt_ack),
        .data_from_cr(data_from_cr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, rw0, rw1;
        logic [15:0] wd0, wd1;
        logic [31:0] ma0, ra0, ma1, ra1;
        int          d;
        logic [15:0] din;
        logic        eo;
        logic [15:0] er;
        logic        ee;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_fields(input string nm, input logic eo);
        chk(nm, {dt_rw, data_to_cr}, eo ? {m1_rw, m1_wdata} : {m0_rw, m0_wdata});
        chk(nm, max_addr, eo ? m1_max_addr : m0_max_addr);
        chk(nm, reg_addr, eo ? m1_reg_addr : m0_reg_addr);
    endtask

    // called at a negedge in IDLE; returns at a negedge in the following IDLE cycle
    task automatic run(input logic r0, input logic r1, input int d, input logic [15:0] din,
                       input logic eo, input logic [15:0] er, input logic ee);
        int p, ap;
        m0_req = r0;
        m1_req = r1;
        data_from_cr = din;
        ap = (d != 0) ? 2 + d : 2 + TO;
        @(negedge clk);
        p = 1;
        chk("issue_dt_req", {dt_req, busy}, 2'b11);
        chk_fields("issue_fields", eo);
        forever begin
            @(negedge clk);
            p++;
            dt_ack = 1'b0;
            if (m0_ack || m1_ack || p > 40) break;
            chk("wait_dt_req", dt_req, 1'b1);
            chk_fields("wait_hold", eo);
            dt_ack = (d != 0 && p == 1 + d);
        end
        chk("ack_cycle", p, ap);
        chk("ack_owner", {m0_ack, m1_ack}, {!eo, eo});
        chk("err_flags", {m0_err, m1_err}, {ee && !eo, ee && eo});
        chk("rdata", rdata, er);
        chk("done_dt_req", {dt_req, busy}, 2'b01);
        if (eo) m1_req = 1'b0;
        else m0_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse_end", {m0_ack, m1_ack, m0_err, m1_err, busy}, 5'b0);
    endtask

    initial begin
        int ord[10];
        ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h100, 32'h0, 32'h0, 32'h0,
                  3, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h1234, 32'h0, 32'h0, 32'h2000, 32'h8,
                  2, 16'h5555, 1'b1, 16'h5555, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h300, 32'h4, 32'h0, 32'h0,
                  0, 16'hAAAA, 1'b0, 16'h0000, 1'b1};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hC0DE, 16'h0, 32'h400, 32'hC, 32'h0, 32'h0,
                  1, 16'h0F0F, 1'b0, 16'h0F0F, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 32'h500, 32'h10, 32'h600, 32'h14,
                  2, 16'h2468, 1'b0, 16'h2468, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0, 32'h700, 32'h18,
                  4, 16'h1357, 1'b1, 16'h1357, 1'b0};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h800, 32'h1C, 32'h0, 32'h0,
                  TO, 16'h9ABC, 1'b0, 16'h9ABC, 1'b0};
        repeat (2) @(negedge clk);
        chk("reset_outputs", {m0_ack, m0_err, m1_ack, m1_err, dt_req, dt_rw, busy}, 7'b0);
        chk("reset_data", {rdata, data_to_cr}, 32'h0);
        chk("reset_addr", max_addr | reg_addr, 32'h0);
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            m0_rw = vt[i].rw0; m0_wdata = vt[i].wd0; m0_max_addr = vt[i].ma0; m0_reg_addr = vt[i].ra0;
            m1_rw = vt[i].rw1; m1_wdata = vt[i].wd1; m1_max_addr = vt[i].ma1; m1_reg_addr = vt[i].ra1;
            run(vt[i].r0, vt[i].r1, vt[i].d, vt[i].din, vt[i].eo, vt[i].er, vt[i].ee);
        end
        // reset during WAIT abandons the transaction silently
        m0_max_addr = 32'hDEAD; m0_wdata = 16'hFFFF; m0_rw = 1'b1;
        m0_req = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_wait_ctrl", {dt_req, busy, m0_ack, m0_err, dt_rw}, 5'b0);
        chk("clr_wait_data", {rdata, data_to_cr}, 32'h0);
        chk("clr_wait_addr", max_addr, 32'h0);
        m0_req = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_no_ack", {m0_ack, m1_ack, busy}, 3'b0);
        m1_rw = 1'b0; m1_wdata = 16'h0; m1_max_addr = 32'h900; m1_reg_addr = 32'h20;
        run(1'b0, 1'b1, 2, 16'h4242, 1'b1, 16'h4242, 1'b0);
        // stray dt_ack while idle must not complete anything
        dt_ack = 1'b1;
        @(negedge clk);
        dt_ack = 1'b0;
        chk("stray_ack", {m0_ack, m1_ack, dt_req, busy}, 4'b0);
        @(negedge clk);
        chk("stray_ack_late", {m0_ack, m1_ack, busy}, 3'b0);
        m0_rw = 1'b0; m0_wdata = 16'h0; m0_max_addr = 32'hA00; m0_reg_addr = 32'h24;
        run(1'b1, 1'b0, 3, 16'h7777, 1'b0, 16'h7777, 1'b0);
        // fairness from a fresh reset with both ports requesting continuously
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m1_max_addr = 32'hB00;
        for (int i = 0; i < 10; i++)
            run(1'b1, 1'b1, 1, 16'(i), ord[i][0], 16'(i), 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
